// File: rtl/prefetch_queue.sv
// -----------------------------------------------------------------------------
// prefetch_queue
//
// Instruction prefetch queue ahead of the fetch/decode boundary. It reads
// 16-bit instructions from instruction memory over a req/ack handshake,
// buffers them with their addresses in a DEPTH-entry FIFO, and presents the
// head entry to decode under a valid/ready handshake. A flush from decode
// empties the queue and restarts fetching at the redirect target. A response
// still in flight at the time of the flush is waited out and discarded.
//
// Ports
//   clk          clock, rising edge
//   reset        asynchronous active-low reset
//   imem_req     registered read request
//   imem_addr    registered read address, stable while imem_req=1
//   imem_ack     response strobe, sampled only while imem_req=1
//   imem_rdata   instruction word, valid with imem_ack
//   flush        redirect pulse from decode
//   flush_pc     redirect target
//   ir_valid     head entry valid
//   ir_ready     decode accepts the head entry
//   ir           head instruction (0 when empty)
//   pc           head instruction address (0 when empty)
//   pc_p2        pc + 2, modulo 2^16
//   count        current occupancy, 0..DEPTH
//
// Build option
//   PREFETCH_STATS_EN  adds stat_flush / stat_drop saturating 16-bit counters
//                      (flush cycles, discarded memory responses).
//
// States
//   IDLE  | no request outstanding (queue full, or just out of reset)
//   REQ   | request outstanding at fetch_pc, response will be pushed
//   DRAIN | stale request outstanding after a flush, response will be dropped
// -----------------------------------------------------------------------------
module prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   imem_req,
    output logic [15:0]            imem_addr,
    input  logic                   imem_ack,
    input  logic [15:0]            imem_rdata,
    input  logic                   flush,
    input  logic [15:0]            flush_pc,
    output logic                   ir_valid,
    input  logic                   ir_ready,
    output logic [15:0]            ir,
    output logic [15:0]            pc,
    output logic [15:0]            pc_p2,
    output logic [$clog2(DEPTH):0] count
`ifdef PREFETCH_STATS_EN
    ,
    output logic [15:0]            stat_flush,
    output logic [15:0]            stat_drop
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           req_q, req_d;
    logic [15:0]    addr_q, addr_d;
    logic [15:0]    fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]  count_q, count_d;
    logic [PW-1:0]  wptr_q, wptr_d;
    logic [PW-1:0]  rptr_q, rptr_d;
    logic           push, pop;

    logic [15:0]    mem_ir [DEPTH];
    logic [15:0]    mem_pc [DEPTH];

    always_comb begin
        pop  = (count_q != '0) && ir_ready && !flush;
        push = (state_q == S_REQ) && imem_ack && !flush;

        state_d    = state_q;
        addr_d     = addr_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;

        if (flush) begin
            count_d    = '0;
            wptr_d     = '0;
            rptr_d     = '0;
            fetch_pc_d = flush_pc;
            case (state_q)
                S_REQ, S_DRAIN: begin
                    // An unanswered request must complete before the new
                    // target can be issued; an answered one is simply dropped.
                    if (imem_ack) begin
                        state_d = S_REQ;
                        addr_d  = flush_pc;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
                default: begin
                    state_d = S_REQ;
                    addr_d  = flush_pc;
                end
            endcase
        end else begin
            if (push) begin
                wptr_d     = wptr_q + PW'(1);
                fetch_pc_d = fetch_pc_q + 16'd2;
            end
            if (pop) begin
                rptr_d = rptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase

            case (state_q)
                S_IDLE: begin
                    if (count_d < DEPTH_C) begin
                        state_d = S_REQ;
                        addr_d  = fetch_pc_q;
                    end
                end
                S_REQ: begin
                    if (imem_ack) begin
                        addr_d = fetch_pc_d;
                        if (count_d >= DEPTH_C) begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (imem_ack) begin
                        state_d = S_REQ;
                        addr_d  = fetch_pc_q;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        req_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    // Storage needs no reset: outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_ir[wptr_q] <= imem_rdata;
            mem_pc[wptr_q] <= fetch_pc_q;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign count     = count_q;
    assign ir_valid  = (count_q != '0);
    assign ir        = ir_valid ? mem_ir[rptr_q] : 16'h0000;
    assign pc        = ir_valid ? mem_pc[rptr_q] : 16'h0000;
    assign pc_p2     = pc + 16'd2;

`ifdef PREFETCH_STATS_EN
    logic        drop;
    logic [15:0] stat_flush_q;
    logic [15:0] stat_drop_q;

    // A response is discarded when it lands with a flush or while draining.
    assign drop = imem_ack && (((state_q == S_REQ) && flush) || (state_q == S_DRAIN));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_flush_q <= 16'h0000;
            stat_drop_q  <= 16'h0000;
        end else begin
            if (flush && (stat_flush_q != 16'hFFFF)) begin
                stat_flush_q <= stat_flush_q + 16'd1;
            end
            if (drop && (stat_drop_q != 16'hFFFF)) begin
                stat_drop_q <= stat_drop_q + 16'd1;
            end
        end
    end

    assign stat_flush = stat_flush_q;
    assign stat_drop  = stat_drop_q;
`else
    // Statistics counters are not present in this build.
`endif

endmodule
